// File: rtl/sd_pkg.sv
// Shared definitions for the SD card block loader: SD slave register map,
// loader state encoding and the byte-swap helper used for swapped registers.
package sd_pkg;

    localparam logic [15:0] SD_REG_ADDR  = 16'h1000;
    localparam logic [15:0] SD_REG_RD    = 16'h1004;
    localparam logic [15:0] SD_REG_WR    = 16'h1008;
    localparam logic [15:0] SD_REG_READY = 16'h2010;

    localparam int READY_BIT   = 24;
    localparam int BLOCK_WORDS = 128;

    // The swapped read-trigger register expects the value 1 as seen by the card.
    localparam logic [31:0] SD_TRIG_VAL = 32'h0100_0000;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WAIT_RDY = 4'd1,
        ST_SET_ADDR = 4'd2,
        ST_TRIG     = 4'd3,
        ST_POLL     = 4'd4,
        ST_COPY     = 4'd5,
        ST_NEXT     = 4'd6,
        ST_FINISH   = 4'd7,
        ST_ABORT    = 4'd8
    } sd_ldr_state_t;

    function automatic logic [31:0] byte_swap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/sd_port_mux.sv
// Combinational owner select for the SD slave MMIO port: CPU when idle,
// engine when busy. CPU read data is forced to zero while the engine owns it.
module sd_port_mux (
    input  logic        sel_engine,
    input  logic [15:0] cpu_a,
    input  logic [31:0] cpu_d,
    input  logic        cpu_we,
    output logic [31:0] cpu_spo,
    input  logic [15:0] eng_a,
    input  logic [31:0] eng_d,
    input  logic        eng_we,
    output logic [15:0] sd_a,
    output logic [31:0] sd_d,
    output logic        sd_we,
    input  logic [31:0] sd_spo
);

    // Route the SD port to its current owner.
    always_comb begin
        sd_a    = 16'd0;
        sd_d    = 32'd0;
        sd_we   = 1'b0;
        cpu_spo = 32'd0;
        if (sel_engine) begin
            sd_a    = eng_a;
            sd_d    = eng_d;
            sd_we   = eng_we;
            cpu_spo = 32'd0;
        end else begin
            sd_a    = cpu_a;
            sd_d    = cpu_d;
            sd_we   = cpu_we;
            cpu_spo = sd_spo;
        end
    end

endmodule

// File: rtl/sd_block_loader.sv
// Copies N consecutive 512-byte SD blocks into main memory, owning the
// SD MMIO port while busy and passing CPU accesses through otherwise.
module sd_block_loader
    import sd_pkg::*;
#(
    parameter int              ADDR_STEP    = 1,
    parameter int              TO_W         = 24,
    parameter logic [TO_W-1:0] POLL_TIMEOUT = TO_W'(24'd10000000)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] src_block,
    input  logic [31:0] dst_addr,
    input  logic [15:0] nblocks,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic [15:0] cpu_a,
    input  logic [31:0] cpu_d,
    input  logic        cpu_we,
    output logic [31:0] cpu_spo,
    output logic [15:0] sd_a,
    output logic [31:0] sd_d,
    output logic        sd_we,
    input  logic [31:0] sd_spo,
    output logic [31:0] mem_a,
    output logic [31:0] mem_d,
    output logic        mem_we,
    input  logic        mem_ready
);

    localparam logic [31:0] ADDR_STEP_W = 32'(ADDR_STEP);
    localparam logic [6:0]  LAST_WORD   = 7'(BLOCK_WORDS - 1);

    sd_ldr_state_t   state_r;
    logic [31:0]     cur_addr_r;
    logic [29:0]     wptr_r;
    logic [15:0]     remaining_r;
    logic [6:0]      k_r;
    logic [TO_W-1:0] to_r;
    logic            busy_r;
    logic            done_r;
    logic            err_r;
    logic [31:0]     mem_a_r;
    logic [31:0]     mem_d_r;
    logic            mem_we_r;

    logic [15:0]     eng_a_s;
    logic [31:0]     eng_d_s;
    logic            eng_we_s;
    logic            ready_s;
    logic            to_hit_s;
    logic            unused_dst_lsb_s;

    assign ready_s          = sd_spo[READY_BIT];
    assign to_hit_s         = (to_r == (POLL_TIMEOUT - TO_W'(1)));
    assign unused_dst_lsb_s = ^dst_addr[1:0];

    assign busy   = busy_r;
    assign done   = done_r;
    assign err    = err_r;
    assign mem_a  = mem_a_r;
    assign mem_d  = mem_d_r;
    assign mem_we = mem_we_r;

    // Engine-side SD access, decoded from the registered state.
    always_comb begin
        eng_a_s  = 16'd0;
        eng_d_s  = 32'd0;
        eng_we_s = 1'b0;
        case (state_r)
            ST_WAIT_RDY, ST_POLL: eng_a_s = SD_REG_READY;
            ST_SET_ADDR: begin
                eng_a_s  = SD_REG_ADDR;
                eng_d_s  = byte_swap(cur_addr_r);
                eng_we_s = 1'b1;
            end
            ST_TRIG: begin
                eng_a_s  = SD_REG_RD;
                eng_d_s  = SD_TRIG_VAL;
                eng_we_s = 1'b1;
            end
            ST_COPY: eng_a_s = {7'd0, k_r, 2'b00};
            default: eng_a_s = 16'd0;
        endcase
    end

    sd_port_mux u_mux (
        .sel_engine (busy_r),
        .cpu_a      (cpu_a),
        .cpu_d      (cpu_d),
        .cpu_we     (cpu_we),
        .cpu_spo    (cpu_spo),
        .eng_a      (eng_a_s),
        .eng_d      (eng_d_s),
        .eng_we     (eng_we_s),
        .sd_a       (sd_a),
        .sd_d       (sd_d),
        .sd_we      (sd_we),
        .sd_spo     (sd_spo)
    );

    // Loader sequencer; done is raised on entry to FINISH/ABORT so it is high during those states.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cur_addr_r  <= 32'd0;
            wptr_r      <= 30'd0;
            remaining_r <= 16'd0;
            k_r         <= 7'd0;
            to_r        <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            mem_a_r     <= 32'd0;
            mem_d_r     <= 32'd0;
            mem_we_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        cur_addr_r  <= src_block;
                        wptr_r      <= dst_addr[31:2];
                        remaining_r <= nblocks;
                        err_r       <= 1'b0;
                        to_r        <= '0;
                        if (nblocks == 16'd0) begin
                            done_r <= 1'b1;
                            busy_r <= 1'b0;
                        end else begin
                            busy_r  <= 1'b1;
                            state_r <= ST_WAIT_RDY;
                        end
                    end
                end
                ST_WAIT_RDY, ST_POLL: begin
                    if (ready_s) begin
                        to_r    <= '0;
                        k_r     <= 7'd0;
                        state_r <= (state_r == ST_WAIT_RDY) ? ST_SET_ADDR : ST_COPY;
                    end else if (to_hit_s) begin
                        done_r  <= 1'b1;
                        err_r   <= 1'b1;
                        state_r <= ST_ABORT;
                    end else begin
                        to_r <= to_r + TO_W'(1);
                    end
                end
                ST_SET_ADDR: state_r <= ST_TRIG;
                ST_TRIG: begin
                    to_r    <= '0;
                    state_r <= ST_POLL;
                end
                ST_COPY: begin
                    // Capture one word, then hold it until memory accepts.
                    if (!mem_we_r) begin
                        mem_a_r  <= {wptr_r, 2'b00};
                        mem_d_r  <= sd_spo;
                        mem_we_r <= 1'b1;
                    end else if (mem_ready) begin
                        mem_we_r <= 1'b0;
                        wptr_r   <= wptr_r + 30'd1;
                        k_r      <= k_r + 7'd1;
                        if (k_r == LAST_WORD) begin
                            state_r <= ST_NEXT;
                        end
                    end
                end
                ST_NEXT: begin
                    cur_addr_r  <= cur_addr_r + ADDR_STEP_W;
                    remaining_r <= remaining_r - 16'd1;
                    if (remaining_r == 16'd1) begin
                        done_r  <= 1'b1;
                        state_r <= ST_FINISH;
                    end else begin
                        state_r <= ST_SET_ADDR;
                    end
                end
                ST_FINISH, ST_ABORT: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r   <= 1'b0;
                    mem_we_r <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sd_block_loader.md
Name: sd_block_loader

Overview:
- Sequencer and arbiter in front of the memory-mapped SD card block: copies N consecutive 512-byte SD blocks into main memory without CPU involvement (boot load, bulk read).
- Shares the SD card MMIO port between the CPU and its own engine. While busy, the engine owns the port and CPU accesses are blocked.
- Sits between the CPU bus decoder, the SD card slave and the main memory write port.

Parameters:
- ADDR_STEP, 1: increment of the SD address per block. Use 1 for block-addressed cards and 512 for byte-addressed cards.
- POLL_TIMEOUT, 24'd10000000: maximum cycles spent polling ready per phase before aborting.
- TO_W, 24: width of the timeout counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- src_block  in  32  first SD address (card units)
- dst_addr  in  32  byte address of the first destination word; low 2 bits ignored
- nblocks  in  16  number of blocks to copy
- busy  out  1  engine owns the SD port
- done  out  1  one-cycle pulse at completion or abort
- err  out  1  sticky timeout flag; cleared by the next accepted start
- cpu_a  in  16  CPU-side SD register address (byte, x4)
- cpu_d  in  32  CPU write data
- cpu_we  in  1  CPU write enable
- cpu_spo  out  32  CPU read data
- sd_a  out  16  to SD slave address
- sd_d  out  32  to SD slave write data
- sd_we  out  1  to SD slave write enable
- sd_spo  in  32  from SD slave read data (combinational)
- mem_a  out  32  memory write address
- mem_d  out  32  memory write data
- mem_we  out  1  memory write request; held until accepted
- mem_ready  in  1  memory accepts the write this cycle

Behaviour:
- Reset: state IDLE; busy=0, done=0, err=0, sd_we=0, mem_we=0, mem_a=0, mem_d=0; all counters cleared.
- Arbitration:
  - busy=0: sd_a/sd_d/sd_we = cpu_a/cpu_d/cpu_we, and cpu_spo = sd_spo, all combinationally.
  - busy=1: the engine drives the SD port, cpu_we is discarded (no effect, not queued) and cpu_spo=0.
- Register conventions of the SD slave:
  - Writes to 0x1000/0x1004 are byte-swapped, so the engine writes {x[7:0],x[15:8],x[23:16],x[31:24]}.
  - The read-trigger value 1 is written as 32'h0100_0000.
  - Ready is read at 0x2010, bit 24.
  - Cache words at 0x000-0x1FC are copied unswapped.
- FSM:
  - IDLE: on start, latch src_block → cur_addr, dst_addr[31:2] → wptr, nblocks → remaining; err<=0; busy<=1. If nblocks==0, pulse done next cycle and stay IDLE with busy=0. Otherwise go to WAIT_RDY.
  - WAIT_RDY: sd_a=0x2010 and sd_we=0. When sd_spo[24]=1, go to SET_ADDR. Timeout counter increments each cycle; on reaching POLL_TIMEOUT go to ABORT.
  - SET_ADDR: one cycle, sd_a=0x1000, sd_we=1, sd_d=swap(cur_addr). Then TRIG.
  - TRIG: one cycle, sd_a=0x1004, sd_we=1, sd_d=32'h0100_0000. Then POLL.
  - POLL: as WAIT_RDY (timeout counter restarted). Ready may be observed low for any number of cycles, including zero beyond the first. On ready=1, word index k<=0 and go to COPY.
  - COPY: sd_a={k,2'b00}. When mem_we=0, load mem_a={wptr,2'b00}, mem_d=sd_spo and set mem_we=1. Hold all three until the cycle mem_ready=1; in that cycle mem_we<=0, wptr<=wptr+1 and k<=k+1. After k=127 is accepted go to NEXT. Each word takes at least 2 cycles.
  - NEXT: cur_addr<=cur_addr+ADDR_STEP (32-bit wrap), remaining<=remaining-1. If remaining==1, go to FINISH; else go to SET_ADDR.
  - FINISH: done=1 for one cycle, busy<=0, go to IDLE.
  - ABORT: err<=1, done=1 for one cycle, busy<=0, go to IDLE. mem_we must already be 0 here, since timeout only occurs in the poll states.
- Boundary and timing rules:
  - start while busy: ignored.
  - Reset mid-transfer: immediate return to IDLE with reset values; no partial mem_we glitch after the reset cycle.
  - wptr wraps at 2^30 words.
  - Simultaneous start and cpu_we in IDLE: the CPU write passes through that cycle; the engine takes the port the next cycle.
  - Latency for the first SD access after start: 1 cycle.

Decomposition:
- Shared package sd_pkg:
  - register offsets SD_REG_ADDR=16'h1000, SD_REG_RD=16'h1004, SD_REG_WR=16'h1008, SD_REG_READY=16'h2010;
  - READY_BIT=24;
  - BLOCK_WORDS=128;
  - state enum sd_ldr_state_t;
  - byte-swap function.
- One natural sub-module: sd_port_mux (combinational CPU/engine mux on the SD port, reusable for a future write engine).

Test Plan:
1. Reset, then CPU writes 0x1000 with busy=0 → identical values on sd_a/sd_d/sd_we the same cycle; cpu_spo mirrors sd_spo.
2. start, src_block=0x10, dst_addr=0x8000_0000, nblocks=2, SD model ready after 50 cycles, mem_ready always 1 → sd_d=32'h1000_0000 at 0x1000 for the first block and 32'h1100_0000 for the second; 256 mem writes covering 0x8000_0000-0x8000_03FC in order with data equal to the model cache; a single done pulse; err=0.
3. mem_ready low for 5 cycles on word 7 → mem_a/mem_d/mem_we stable for those cycles; no word skipped or duplicated.
4. Model holds ready=0 forever, POLL_TIMEOUT=100 → done pulse after about 100 polling cycles; err=1; busy=0; CPU pass-through restored. The next start clears err.
5. nblocks=0 → done pulse one cycle after start; no sd_we or mem_we.
6. rst asserted during COPY at word 60; cpu_we during busy; start during busy → outputs return to reset values the next cycle; cpu_we has no effect on sd_we; the second start is ignored.
